// File: rtl/cfi_log_arbiter.sv
// Round-robin arbiter sharing one CFI log backend between NR_REQ log queues.
// Grants bounded bursts, rotates fairly, and flags a backend that stops popping.
module cfi_log_arbiter #(
  parameter int NR_REQ         = 2,
  parameter int LOG_W          = 128,
  parameter int MAX_BURST      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NR_REQ*LOG_W-1:0] req_log_i,
  input  logic [NR_REQ-1:0]       req_valid_i,
  output logic [NR_REQ-1:0]       req_pop_o,
  output logic [LOG_W-1:0]        log_o,
  output logic                    log_valid_o,
  input  logic                    log_pop_i,
  output logic [NR_REQ-1:0]       grant_o,
  output logic                    busy_o,
  output logic                    timeout_o,
  input  logic                    clear_timeout_i
);

  localparam int PTR_W   = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               timeout_q, timeout_d;

  logic               busy;
  logic               owner_valid;
  logic               pop;
  logic [PTR_W-1:0]   winner;
  logic               any_req;

  assign busy = (state_q == ST_BUSY);

  // Backend-facing view of the owner queue; everything is gated to 0 outside BUSY.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    log_o       = '0;
    owner_valid = 1'b0;
    grant_o     = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (busy && owner_q == PTR_W'(i)) begin
        log_o       = req_log_i[i*LOG_W +: LOG_W];
        owner_valid = req_valid_i[i];
        grant_o[i]  = 1'b1;
      end
    end
  end

  assign log_valid_o = owner_valid;
  assign busy_o      = busy;
  assign pop         = log_pop_i & owner_valid;
  assign req_pop_o   = grant_o & {NR_REQ{pop}};
  assign any_req     = |req_valid_i;
  assign timeout_o   = timeout_q;

  // Search starts at rr_ptr and wraps explicitly, so NR_REQ need not be a power of 2.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic             found;
    winner = '0;
    found  = 1'b0;
    idx    = rr_ptr_q;
    for (int k = 0; k < NR_REQ; k++) begin
      if (!found && req_valid_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
      idx = (idx == PTR_W'(NR_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d     = winner;
          burst_cnt_d = '0;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (pop) burst_cnt_d = burst_cnt_q + 1'b1;
        if ((pop && burst_cnt_q == BURST_W'(MAX_BURST - 1)) || !owner_valid) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (owner_q == PTR_W'(NR_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Watchdog: the set fires only on the transition into TIMEOUT_CYCLES, so a
  // clear while the counter is saturated restarts a full stall window.
  always_comb begin
    logic               stalled;
    logic               hit;
    logic [STALL_W-1:0] stall_inc;
    stalled   = owner_valid & ~log_pop_i;
    stall_inc = (stall_cnt_q == STALL_W'(TIMEOUT_CYCLES)) ? stall_cnt_q
                                                           : stall_cnt_q + 1'b1;
    hit       = stalled && (stall_cnt_q == STALL_W'(TIMEOUT_CYCLES - 1));
    stall_cnt_d = (clear_timeout_i || !stalled) ? '0 : stall_inc;
    timeout_d   = hit || (timeout_q && !clear_timeout_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_cfi_log_arbiter.sv
// Directed bench for cfi_log_arbiter: a per-cycle vector table plus queue-model
// sequences for bursts, rotation, watchdog and mid-burst reset.
module tb_cfi_log_arbiter;

  localparam int NR_REQ = 2;
  localparam int LOG_W  = 16;
  localparam int MAXB   = 4;
  localparam int TMO    = 16;

  logic                    clk;
  logic                    rst_n;
  logic [NR_REQ*LOG_W-1:0] req_log_i;
  logic [NR_REQ-1:0]       req_valid_i;
  logic [NR_REQ-1:0]       req_pop_o;
  logic [LOG_W-1:0]        log_o;
  logic                    log_valid_o;
  logic                    log_pop_i;
  logic [NR_REQ-1:0]       grant_o;
  logic                    busy_o;
  logic                    timeout_o;
  logic                    clear_timeout_i;

  cfi_log_arbiter #(
    .NR_REQ(NR_REQ), .LOG_W(LOG_W), .MAX_BURST(MAXB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_log_i(req_log_i), .req_valid_i(req_valid_i),
    .req_pop_o(req_pop_o), .log_o(log_o), .log_valid_o(log_valid_o),
    .log_pop_i(log_pop_i), .grant_o(grant_o), .busy_o(busy_o),
    .timeout_o(timeout_o), .clear_timeout_i(clear_timeout_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue model (stimulus source) and direct-drive table inputs.
  logic [LOG_W-1:0] qdat [NR_REQ][32];
  int               qcnt [NR_REQ];
  int               qhd  [NR_REQ];
  bit               use_model;
  logic [NR_REQ-1:0] tbl_valid;
  logic [LOG_W-1:0]  tbl_log [NR_REQ];
  logic [LOG_W-1:0]  got[$];
  int                both_hot;

  always_comb begin
    req_valid_i = '0;
    req_log_i   = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (use_model) begin
        if (qhd[i] < qcnt[i]) begin
          req_valid_i[i]              = 1'b1;
          req_log_i[i*LOG_W +: LOG_W] = qdat[i][qhd[i]];
        end
      end else begin
        req_valid_i[i]              = tbl_valid[i];
        req_log_i[i*LOG_W +: LOG_W] = tbl_log[i];
      end
    end
  end

  task automatic q_clear();
    for (int i = 0; i < NR_REQ; i++) begin
      qcnt[i] = 0;
      qhd[i]  = 0;
    end
  endtask

  task automatic q_push(input int i, input logic [LOG_W-1:0] v);
    qdat[i][qcnt[i]] = v;
    qcnt[i]++;
  endtask

  // One clock: record what the backend consumes, then advance the queue heads.
  task automatic tick();
    logic [NR_REQ-1:0] p;
    p = req_pop_o;
    if (log_pop_i && log_valid_o) got.push_back(log_o);
    if ($countones(p) > 1) both_hot++;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR_REQ; i++)
      if (p[i] && use_model) qhd[i]++;
    @(negedge clk);
    #1;
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (got.size() < n && c < budget) begin
      tick();
      c++;
    end
    check(name, got.size(), n);
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    log_pop_i       = 1'b0;
    clear_timeout_i = 1'b0;
    use_model       = 1'b1;
    q_clear();
    got.delete();
    both_hot = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic        pop;
    logic [1:0]  e_pop;
    logic [1:0]  e_grant;
    logic        e_busy;
    logic        e_lv;
    logic [15:0] e_log;
  } vec_t;

  vec_t vecs [15];

  logic [1:0] t1p [10];
  logic [1:0] t1g [10];
  logic [1:0] t2p [11];
  logic [1:0] t2g [11];

  initial begin
    vecs[0]  = '{2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000};
    vecs[2]  = '{2'b01, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 16'h1111};
    vecs[3]  = '{2'b01, 1'b1, 2'b01, 2'b01, 1'b1, 1'b1, 16'h1111};
    vecs[4]  = '{2'b00, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 16'h1111};
    vecs[5]  = '{2'b11, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000};
    vecs[6]  = '{2'b11, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1, 16'h2222};
    vecs[7]  = '{2'b11, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1, 16'h2222};
    vecs[8]  = '{2'b11, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1, 16'h2222};
    vecs[9]  = '{2'b11, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 16'h2222};
    vecs[10] = '{2'b11, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1, 16'h2222};
    vecs[11] = '{2'b11, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000};
    vecs[12] = '{2'b10, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 16'h1111};
    vecs[13] = '{2'b10, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000};
    vecs[14] = '{2'b10, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1, 16'h2222};

    t1p = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    t1g = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    t2p = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
    t2g = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};

    tbl_valid  = '0;
    tbl_log[0] = 16'h1111;
    tbl_log[1] = 16'h2222;

    // Reset state, with requests pending and the backend trying to pop.
    rst_n = 1'b0;
    log_pop_i = 1'b1;
    clear_timeout_i = 1'b0;
    use_model = 1'b1;
    q_clear();
    q_push(0, 16'hA000);
    q_push(1, 16'hB000);
    #1;
    check("reset_outputs", {req_pop_o, log_o, log_valid_o, grant_o, busy_o, timeout_o}, '0);

    // 1: single requester, burst limit forces a bubble and regrant.
    do_reset();
    for (int k = 0; k < 6; k++) q_push(0, 16'hA000 + 16'(k));
    log_pop_i = 1'b1;
    #1;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("t1_pop_c%0d", c), req_pop_o, t1p[c]);
      check($sformatf("t1_grant_c%0d", c), grant_o, t1g[c]);
      tick();
    end
    check("t1_count", got.size(), 6);
    for (int k = 0; k < 6 && k < got.size(); k++)
      check($sformatf("t1_log%0d", k), got[k], 16'hA000 + 16'(k));
    q_push(0, 16'hA006);
    q_push(1, 16'hB000);
    #1;
    tick();
    check("t1_rr_ptr_next_is_1", grant_o, 2'b10);
    run_until(8, 20, "t1_drain");
    if (got.size() >= 8) begin
      check("t1_drain_first", got[6], 16'hB000);
      check("t1_drain_second", got[7], 16'hA006);
    end

    // 2: two short queues, one after the other.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      q_push(0, 16'hA000 + 16'(k));
      q_push(1, 16'hB000 + 16'(k));
    end
    log_pop_i = 1'b1;
    #1;
    for (int c = 0; c < 11; c++) begin
      check($sformatf("t2_pop_c%0d", c), req_pop_o, t2p[c]);
      check($sformatf("t2_grant_c%0d", c), grant_o, t2g[c]);
      tick();
    end
    check("t2_count", got.size(), 6);
    for (int k = 0; k < 6 && k < got.size(); k++)
      check($sformatf("t2_log%0d", k), got[k],
            (k < 3) ? 16'hA000 + 16'(k) : 16'hB000 + 16'(k - 3));

    // 3: two long queues interleave in bursts of MAXB.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      q_push(0, 16'hA000 + 16'(k));
      q_push(1, 16'hB000 + 16'(k));
    end
    log_pop_i = 1'b1;
    #1;
    run_until(16, 60, "t3_drain");
    for (int k = 0; k < 16 && k < got.size(); k++) begin
      int burst;
      logic [15:0] exp_v;
      burst = k / MAXB;
      exp_v = ((burst % 2) == 0 ? 16'hA000 : 16'hB000) + 16'((burst / 2) * MAXB + (k % MAXB));
      check($sformatf("t3_log%0d", k), got[k], exp_v);
    end
    check("t3_pop_onehot", both_hot, 0);

    // 4: watchdog set, clear, re-arm, and set-wins-over-clear.
    do_reset();
    q_push(0, 16'hA000);
    log_pop_i = 1'b0;
    #1;
    tick();
    begin
      logic early;
      early = 1'b0;
      for (int c = 1; c <= TMO; c++) begin
        if (timeout_o) early = 1'b1;
        tick();
      end
      check("t4_no_early_timeout", early, 1'b0);
      check("t4_timeout_set", timeout_o, 1'b1);
      check("t4_grant_held", grant_o, 2'b01);
      clear_timeout_i = 1'b1;
      tick();
      clear_timeout_i = 1'b0;
      check("t4_timeout_cleared", timeout_o, 1'b0);
      early = 1'b0;
      for (int c = 18; c < 33; c++) begin
        if (timeout_o) early = 1'b1;
        tick();
      end
      check("t4_no_early_rearm", early, 1'b0);
      check("t4_before_reset_edge", timeout_o, 1'b0);
      clear_timeout_i = 1'b1;
      tick();
      clear_timeout_i = 1'b0;
      check("t4_set_wins", timeout_o, 1'b1);
      check("t4_grant_still", grant_o, 2'b01);
    end
    log_pop_i = 1'b1;
    #1;
    check("t4_pop_after_stall", req_pop_o, 2'b01);
    tick();
    check("t4_popped", got.size(), 1);

    // 5: reset mid-burst aborts immediately and restores rr_ptr=0.
    do_reset();
    for (int k = 0; k < 4; k++) q_push(1, 16'hB000 + 16'(k));
    log_pop_i = 1'b1;
    #1;
    tick();
    tick();
    tick();
    check("t5_mid_burst_pop", req_pop_o, 2'b10);
    rst_n = 1'b0;
    #1;
    check("t5_async_outputs", {req_pop_o, log_o, log_valid_o, grant_o, busy_o, timeout_o}, '0);
    tick();
    check("t5_no_pop_in_reset", qhd[1], 2);
    rst_n = 1'b1;
    q_push(0, 16'hA000);
    #1;
    tick();
    check("t5_first_grant_q0", grant_o, 2'b01);

    // 6: per-cycle table, direct-driven inputs.
    do_reset();
    use_model = 1'b0;
    for (int v = 0; v < 15; v++) begin
      tbl_valid = vecs[v].valid;
      log_pop_i = vecs[v].pop;
      #1;
      check($sformatf("t6_v%0d", v),
            {req_pop_o, grant_o, busy_o, log_valid_o, log_o},
            {vecs[v].e_pop, vecs[v].e_grant, vecs[v].e_busy, vecs[v].e_lv, vecs[v].e_log});
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
